// File: rtl/plane_pkg.sv
// Shared types and constants for the falling-plane engine: slot and
// sequencer state encodings, LFSR seed/taps and counter width.
package plane_pkg;

   typedef enum logic [1:0] {
      SLOT_IDLE = 2'd0,
      SLOT_FLY  = 2'd1,
      SLOT_WAIT = 2'd2
   } slot_state_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } seq_state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Taps 16/14/13/11 of the right-shifting Fibonacci form sit on bits 0/2/3/5.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   localparam int              CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/plane_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used as the spawn-position source.
module plane_lfsr
   import plane_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] o_value
);

   logic [15:0] r_lfsr;
   logic        w_feedback;

   assign w_feedback = ^(r_lfsr & LFSR_TAPS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= {w_feedback, r_lfsr[15:1]};
      end
   end

   assign o_value = r_lfsr;

endmodule

// File: rtl/plane_field.sv
// Falling-plane slot engine: one shared update datapath walks all slots
// once per frame tick, spawning, moving, retiring and respawning planes.
module plane_field
   import plane_pkg::*;
#(
   parameter int N_PLANES       = 10,
   parameter int X_W            = 8,
   parameter int Y_W            = 8,
   parameter int X_LIMIT        = 151,
   parameter int Y_LIMIT        = 112,
   parameter int RESPAWN_FRAMES = 4
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tick,
   input  logic [4:0]              plane_amount,
   input  logic [1:0]              flying_rate,
   input  logic [N_PLANES-1:0]     hit,
   output logic [N_PLANES*X_W-1:0] x_flat,
   output logic [N_PLANES*Y_W-1:0] y_flat,
   output logic [N_PLANES-1:0]     vis,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    escaped,
   output logic                    destroyed,
   output logic [CNT_W-1:0]        escape_count,
   output logic [CNT_W-1:0]        destroy_count,
   output logic                    overrun
);

   localparam int             IDX_W    = (N_PLANES > 1) ? $clog2(N_PLANES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PLANES - 1);

   seq_state_t          r_state;
   seq_state_t          w_nextState;
   logic [IDX_W-1:0]    r_idx;
   slot_state_t         r_slot [N_PLANES];
   logic [X_W-1:0]      r_x    [N_PLANES];
   logic [Y_W-1:0]      r_y    [N_PLANES];
   logic [3:0]          r_wait [N_PLANES];
   logic [N_PLANES-1:0] r_pend;
   logic                r_token;
   logic                r_escaped;
   logic                r_destroyed;
   logic                r_overrun;
   logic [CNT_W-1:0]    r_escCnt;
   logic [CNT_W-1:0]    r_desCnt;

   logic [15:0]         w_lfsr;
   logic                w_scanning;
   logic                w_accept;
   logic [4:0]          w_amt;
   logic                w_hitNow;
   logic [X_W-1:0]      w_rand;
   logic [Y_W:0]        w_ySum;
   slot_state_t         w_nSlot;
   logic [X_W-1:0]      w_nX;
   logic [Y_W-1:0]      w_nY;
   logic [3:0]          w_nWait;
   logic                w_esc;
   logic                w_des;
   logic                w_spawn;

   plane_lfsr u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .o_value (w_lfsr)
   );

   assign w_scanning = (r_state == S_SCAN);
   assign w_accept   = tick && !w_scanning;
   assign w_amt      = (plane_amount > 5'(N_PLANES)) ? 5'(N_PLANES) : plane_amount;

   // A tick arriving in the DONE cycle starts the next scan straight away.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (tick) w_nextState = S_SCAN;
         S_SCAN:  if (r_idx == LAST_IDX) w_nextState = S_DONE;
         S_DONE:  w_nextState = tick ? S_SCAN : S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_scanning) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
         end else if (w_accept) begin
            r_idx <= '0;
         end
      end
   end

   // Next value of the slot selected by r_idx; rules are in priority order.
   always_comb begin
      w_hitNow = r_pend[r_idx] | hit[r_idx];
      w_rand   = w_lfsr[X_W-1:0];
      w_ySum   = {1'b0, r_y[r_idx]} + (Y_W+1)'(flying_rate) + (Y_W+1)'(1);
      w_nSlot  = r_slot[r_idx];
      w_nX     = r_x[r_idx];
      w_nY     = r_y[r_idx];
      w_nWait  = r_wait[r_idx];
      w_esc    = 1'b0;
      w_des    = 1'b0;
      w_spawn  = 1'b0;
      if (5'(r_idx) >= w_amt) begin
         w_nSlot = SLOT_IDLE;
      end else begin
         case (r_slot[r_idx])
            SLOT_FLY: begin
               if (w_hitNow) begin
                  w_nSlot = SLOT_WAIT;
                  w_nWait = 4'(RESPAWN_FRAMES);
                  w_des   = 1'b1;
               end else if (w_ySum > (Y_W+1)'(Y_LIMIT)) begin
                  w_nSlot = SLOT_WAIT;
                  w_nWait = 4'(RESPAWN_FRAMES);
                  w_esc   = 1'b1;
               end else begin
                  w_nY = w_ySum[Y_W-1:0];
               end
            end
            SLOT_WAIT: begin
               w_nWait = r_wait[r_idx] - 4'd1;
               if (r_wait[r_idx] <= 4'd2) w_nSlot = SLOT_IDLE;
            end
            default: begin
               if (r_token) begin
                  w_spawn = 1'b1;
                  w_nSlot = SLOT_FLY;
                  w_nY    = '0;
                  w_nX    = ({1'b0, w_rand} <= (X_W+1)'(X_LIMIT)) ?
                            w_rand : w_rand - X_W'(X_LIMIT + 1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_PLANES; i++) begin
            r_slot[i] <= SLOT_IDLE;
            r_x[i]    <= '0;
            r_y[i]    <= '0;
            r_wait[i] <= '0;
         end
         r_pend <= '0;
      end else begin
         r_pend <= r_pend | hit;
         if (w_scanning) begin
            r_slot[r_idx] <= w_nSlot;
            r_x[r_idx]    <= w_nX;
            r_y[r_idx]    <= w_nY;
            r_wait[r_idx] <= w_nWait;
            r_pend[r_idx] <= 1'b0;
         end
      end
   end

   // The spawn token is re-armed when a scan starts and consumed by one spawn.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_token     <= 1'b0;
         r_escaped   <= 1'b0;
         r_destroyed <= 1'b0;
         r_overrun   <= 1'b0;
         r_escCnt    <= '0;
         r_desCnt    <= '0;
      end else begin
         if (w_accept) begin
            r_token <= 1'b1;
         end else if (w_scanning && w_spawn) begin
            r_token <= 1'b0;
         end
         r_escaped   <= w_scanning && w_esc;
         r_destroyed <= w_scanning && w_des;
         r_overrun   <= r_overrun | (tick && w_scanning);
         if (w_scanning && w_esc && (r_escCnt != CNT_MAX)) r_escCnt <= r_escCnt + 1'b1;
         if (w_scanning && w_des && (r_desCnt != CNT_MAX)) r_desCnt <= r_desCnt + 1'b1;
      end
   end

   always_comb begin
      x_flat = '0;
      y_flat = '0;
      vis    = '0;
      for (int i = 0; i < N_PLANES; i++) begin
         x_flat[i*X_W +: X_W] = r_x[i];
         y_flat[i*Y_W +: Y_W] = r_y[i];
         vis[i]               = (r_slot[i] == SLOT_FLY);
      end
   end

   assign busy          = w_scanning;
   assign frame_done    = (r_state == S_DONE);
   assign escaped       = r_escaped;
   assign destroyed     = r_destroyed;
   assign escape_count  = r_escCnt;
   assign destroy_count = r_desCnt;
   assign overrun       = r_overrun;

endmodule

// File: tb/tb_plane_field.sv
// Self-checking bench for plane_field: a frame-level behavioural model is
// compared every cycle, plus scripted scenarios with hand-computed values.
module tb_plane_field;

   localparam int N  = 10;
   localparam int XW = 8;
   localparam int YW = 8;
   localparam int XL = 151;
   localparam int YL = 112;
   localparam int RF = 4;

   localparam int M_IDLE = 0;
   localparam int M_FLY  = 1;
   localparam int M_WAIT = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          tick = 1'b0;
   logic [4:0]    plane_amount = '0;
   logic [1:0]    flying_rate = '0;
   logic [N-1:0]  hit = '0;
   logic [N*XW-1:0] x_flat;
   logic [N*YW-1:0] y_flat;
   logic [N-1:0]  vis;
   logic          busy;
   logic          frame_done;
   logic          escaped;
   logic          destroyed;
   logic [7:0]    escape_count;
   logic [7:0]    destroy_count;
   logic          overrun;

   int errors = 0;
   int checks = 0;

   plane_field #(
      .N_PLANES(N), .X_W(XW), .Y_W(YW), .X_LIMIT(XL), .Y_LIMIT(YL), .RESPAWN_FRAMES(RF)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .plane_amount(plane_amount),
      .flying_rate(flying_rate), .hit(hit), .x_flat(x_flat), .y_flat(y_flat),
      .vis(vis), .busy(busy), .frame_done(frame_done), .escaped(escaped),
      .destroyed(destroyed), .escape_count(escape_count),
      .destroy_count(destroy_count), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: frame-level slot rules keyed on the cycle count
   // since the accepted tick, using the spec's LFSR sequence for spawns.
   int          mState [N];
   int          mX [N];
   int          mY [N];
   int          mWait [N];
   bit          mPend [N];
   bit          mToken = 0;
   int          cyc = 0;
   int          start = -1000;
   logic [15:0] mLfsr = 16'hACE1;
   bit          mEsc = 0;
   bit          mDes = 0;
   bit          mOver = 0;
   int          mEscCnt = 0;
   int          mDesCnt = 0;
   int          amt;
   int          k;
   int          r;
   bit          busyNow;
   bit          e;
   bit          d;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            mState[i] = M_IDLE; mX[i] = 0; mY[i] = 0; mWait[i] = 0; mPend[i] = 0;
         end
         mToken = 0; cyc = 0; start = -1000; mLfsr = 16'hACE1;
         mEsc = 0; mDes = 0; mOver = 0; mEscCnt = 0; mDesCnt = 0;
      end else begin
         e = 0;
         d = 0;
         for (int i = 0; i < N; i++) mPend[i] = mPend[i] | hit[i];
         busyNow = (cyc > start) && (cyc <= start + N);
         if (busyNow) begin
            k   = cyc - start - 1;
            amt = (int'(plane_amount) > N) ? N : int'(plane_amount);
            if (k >= amt) begin
               mState[k] = M_IDLE;
            end else if (mState[k] == M_FLY) begin
               if (mPend[k]) begin
                  mState[k] = M_WAIT; mWait[k] = RF; d = 1;
               end else if (mY[k] + int'(flying_rate) + 1 > YL) begin
                  mState[k] = M_WAIT; mWait[k] = RF; e = 1;
               end else begin
                  mY[k] = mY[k] + int'(flying_rate) + 1;
               end
            end else if (mState[k] == M_WAIT) begin
               mWait[k] = mWait[k] - 1;
               if (mWait[k] <= 1) mState[k] = M_IDLE;
            end else if (mToken) begin
               r = int'(mLfsr[7:0]);
               mX[k] = (r <= XL) ? r : r - XL - 1;
               mY[k] = 0;
               mState[k] = M_FLY;
               mToken = 0;
            end
            mPend[k] = 0;
         end
         if (tick) begin
            if (busyNow) mOver = 1;
            else begin
               start  = cyc;
               mToken = 1;
            end
         end
         mEsc = e;
         mDes = d;
         if (e && mEscCnt < 255) mEscCnt++;
         if (d && mDesCnt < 255) mDesCnt++;
         mLfsr = {mLfsr[0] ^ mLfsr[2] ^ mLfsr[3] ^ mLfsr[5], mLfsr[15:1]};
         cyc++;
      end
   end

   // Compare every cycle, away from the active edge.
   logic [N*XW-1:0] expX;
   logic [N*YW-1:0] expY;
   logic [N-1:0]    expVis;
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         expX[i*XW +: XW] = XW'(mX[i]);
         expY[i*YW +: YW] = YW'(mY[i]);
         expVis[i]        = (mState[i] == M_FLY);
      end
      checkOutput("x_flat", x_flat, expX);
      checkOutput("y_flat", y_flat, expY);
      checkOutput("vis", vis, expVis);
      checkOutput("busy", busy, (cyc > start) && (cyc <= start + N));
      checkOutput("frame_done", frame_done, cyc == start + N + 1);
      checkOutput("escaped", escaped, mEsc);
      checkOutput("destroyed", destroyed, mDes);
      checkOutput("escape_count", escape_count, mEscCnt);
      checkOutput("destroy_count", destroy_count, mDesCnt);
      checkOutput("overrun", overrun, mOver);
   end

   task automatic doReset();
      @(posedge clk); #1;
      reset = 1'b1; tick = 1'b0; hit = '0;
      @(negedge clk);
      checkOutput("rst_vis", vis, 0);
      checkOutput("rst_xy", {x_flat, y_flat}, 0);
      checkOutput("rst_cnt", {escape_count, destroy_count, overrun, busy}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic waitFrame();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 40);
      checkOutput("frame_timeout", frame_done, 1);
   endtask

   task automatic applyStimulus(input int nTicks);
      for (int t = 0; t < nTicks; t++) begin
         @(posedge clk); #1 tick = 1'b1;
         @(posedge clk); #1 tick = 1'b0;
         waitFrame();
      end
   endtask

   task automatic pulseHit(input logic [N-1:0] v);
      @(posedge clk); #1 hit = v;
      @(posedge clk); #1 hit = '0;
   endtask

   initial begin
      doReset();

      // Reset then spawn: one new plane per frame.
      plane_amount = 5'd3; flying_rate = 2'd0;
      applyStimulus(1); checkOutput("spawn_t1", vis, 10'b0000000001);
      applyStimulus(1); checkOutput("spawn_t2", vis, 10'b0000000011);
      applyStimulus(1); checkOutput("spawn_t3", vis, 10'b0000000111);
      applyStimulus(1); checkOutput("spawn_y0", y_flat[7:0], 3);

      // Escape at y=112 with step 4, respawn four ticks later, then a hit.
      doReset();
      plane_amount = 5'd1; flying_rate = 2'd3;
      applyStimulus(29); checkOutput("esc_y112", y_flat[7:0], 112);
      applyStimulus(1);
      checkOutput("esc_cnt", escape_count, 1);
      checkOutput("esc_vis", vis[0], 0);
      applyStimulus(3); checkOutput("esc_wait_vis", vis[0], 0);
      applyStimulus(1); checkOutput("esc_respawn", vis[0], 1);
      pulseHit(10'b1);
      applyStimulus(1);
      checkOutput("hit_cnt", destroy_count, 1);
      checkOutput("hit_vis", vis[0], 0);

      // Hit on the escape frame wins.
      doReset();
      plane_amount = 5'd1; flying_rate = 2'd3;
      applyStimulus(29);
      pulseHit(10'b1);
      applyStimulus(1);
      checkOutput("prio_des", destroy_count, 1);
      checkOutput("prio_esc", escape_count, 0);

      // Amount reduction retires slots silently.
      doReset();
      plane_amount = 5'd10; flying_rate = 2'd0;
      applyStimulus(10); checkOutput("amt_all", vis, 10'h3FF);
      plane_amount = 5'd2;
      applyStimulus(1);
      checkOutput("amt_two", vis, 10'h003);
      checkOutput("amt_cnt", {escape_count, destroy_count}, 0);

      // Overrun: tick at t and t+3, single frame_done at t+11.
      doReset();
      plane_amount = 5'd10;
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      for (int j = 4; j <= 14; j++) begin
         @(negedge clk);
         checkOutput($sformatf("ovr_fd_t%0d", j), frame_done, j == 11);
         @(posedge clk); #1;
      end
      checkOutput("ovr_flag", overrun, 1);

      // Reset in the middle of a scan.
      doReset();
      plane_amount = 5'd10;
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst", {vis, busy, frame_done}, 0);
      @(posedge clk); #1 reset = 1'b0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         checkOutput("mid_rst_fd", frame_done, 0);
      end

      // Escape counter saturation.
      doReset();
      plane_amount = 5'd10; flying_rate = 2'd3;
      applyStimulus(1000);
      checkOutput("sat_esc", escape_count, 255);

      // Randomised frames: amount (incl. >N), rate, hits, early ticks.
      doReset();
      for (int it = 0; it < 250; it++) begin
         if ($urandom_range(0, 3) == 0) plane_amount = 5'($urandom_range(0, 20));
         flying_rate = 2'($urandom_range(0, 3));
         @(posedge clk); #1;
         tick = 1'b1;
         hit  = ($urandom_range(0, 2) == 0) ? (N'($urandom) & N'($urandom)) : '0;
         for (int g = $urandom_range(0, 14); g > 0; g--) begin
            @(posedge clk); #1;
            tick = ($urandom_range(0, 9) == 0);
            hit  = ($urandom_range(0, 4) == 0) ? (N'($urandom) & N'($urandom)) : '0;
         end
         @(posedge clk); #1;
         tick = 1'b0;
         hit  = '0;
      end
      repeat (15) @(posedge clk);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/plane_field.md
# plane_field

Parametrised falling-plane engine for the game datapath: owns N plane slots, each with an x/y coordinate, a visibility bit and a lifecycle state. It spawns planes at pseudo-random x positions, advances them once per frame tick at a selectable rate, retires them on hit or on reaching the bottom edge, and respawns them after a delay. It sits between the game FSM, which supplies the frame ticks, and the draw/erase datapath, which reads coordinates once `frame_done` pulses.

## Interface
- `N_PLANES`, 10: number of plane slots, 1..16.
- `X_W`, 8: x coordinate width.
- `Y_W`, 8: y coordinate width.
- `X_LIMIT`, 151: largest legal spawn x. Must satisfy X_LIMIT+1 ≥ 2^(X_W-1).
- `Y_LIMIT`, 112: largest legal y. A plane whose next y would exceed this escapes.
- `RESPAWN_FRAMES`, 4: number of frames a slot waits before respawning, 1..15.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `tick` in 1: one-cycle frame-update request.
- `plane_amount` in 5: requested active slots. Values above N_PLANES saturate to N_PLANES.
- `flying_rate` in 2: vertical step per frame is flying_rate+1 pixels.
- `hit` in N_PLANES: per-slot destroy pulses, accepted on any cycle.
- `x_flat` out N_PLANES*X_W: slot i x coordinate at bits [i*X_W +: X_W].
- `y_flat` out N_PLANES*Y_W: slot i y coordinate at bits [i*Y_W +: Y_W].
- `vis` out N_PLANES: slot visible (state FLY).
- `busy` out 1: a scan is in progress.
- `frame_done` out 1: one-cycle pulse at the end of a scan.
- `escaped` out 1: one-cycle pulse when a slot escapes.
- `destroyed` out 1: one-cycle pulse when a slot is destroyed.
- `escape_count` out 8: saturating count of escapes.
- `destroy_count` out 8: saturating count of destroys.
- `overrun` out 1: sticky flag, set when a tick is dropped.

## Operation
- **Slot state.** Each slot is in one of IDLE, FLY or WAIT. Each slot also holds a 4-bit wait counter and a pending-hit bit.
- **Hit latching.** `hit[i]` ORs into pending[i] on every cycle. pending[i] is cleared when slot i is processed. A hit arriving in the same cycle that slot i is processed counts toward that processing.
- **Sequencer.** The sequencer has states S_IDLE, S_SCAN and S_DONE.
  - In S_IDLE, `tick` moves it to S_SCAN with idx=0.
  - In S_SCAN, it processes slot idx each cycle and increments idx. After idx = N_PLANES-1 it moves to S_DONE.
  - In S_DONE, it pulses `frame_done` and returns to S_IDLE.
- **Per-slot rules**, with amt = min(plane_amount, N_PLANES) and rules applied in priority order:
  1. If idx ≥ amt, the slot goes to IDLE, vis=0, and pending is cleared. The coordinates hold.
  2. FLY with pending set: the slot goes to WAIT, wait counter = RESPAWN_FRAMES, and `destroyed` pulses. A hit takes priority over an escape in the same frame.
  3. FLY where y + flying_rate + 1 > Y_LIMIT: the slot goes to WAIT and `escaped` pulses. y holds its old value.
  4. FLY otherwise: y ← y + flying_rate + 1.
  5. WAIT: the wait counter decrements. When it reaches 1, the slot goes to IDLE.
  6. IDLE: the slot spawns only if the spawn token is free. The token is freed at the start of every scan, so at most one spawn happens per frame. On spawn: x ← r if r ≤ X_LIMIT, else r − X_LIMIT − 1, where r = lfsr[X_W-1:0]; y ← 0; the slot goes to FLY.
- **Pending hits on non-FLY slots.** A pending hit on a slot that is not in FLY is discarded.
- **LFSR.** 16-bit Fibonacci, taps 16/14/13/11, seed 16'hACE1, advancing every cycle including while idle.
- **Counters.** `escape_count` and `destroy_count` saturate at 255.
- **Overrun.** A `tick` received while `busy` is dropped and sets `overrun`.
- **Reset values.** All outputs are 0. All slots are IDLE with x=y=0. pending=0, counters=0, overrun=0, and the sequencer is in S_IDLE.
- **Reset mid-scan.** Reset during a scan aborts it immediately, and no `frame_done` is produced.

## Timing
- `tick` high in cycle t: `busy`=1 from t+1 through t+N_PLANES.
- Slot i's registered update is visible at t+2+i.
- `frame_done`=1 at t+1+N_PLANES. `busy`=0 in that same cycle. The next `tick` is accepted from t+1+N_PLANES.
- `escaped`/`destroyed` pulse in the cycle after slot i is processed, i.e. aligned with slot i's coordinate update.
- `x_flat`, `y_flat` and `vis` change only while `busy`=1. The draw logic samples them after `frame_done`.

## Structure
- **Package `plane_pkg`:**
  - Slot-state enum (IDLE/FLY/WAIT) and sequencer-state enum.
  - LFSR seed and tap constants.
  - Counter width 8.
- **Sub-module `plane_lfsr`:** a 16-bit free-running LFSR with asynchronous reset to the seed.
- **Top module:** the slot register arrays are indexed by idx, giving a single shared update datapath rather than N replicated ones.

## Test plan
- **Reset then spawn.** Reset, then plane_amount=3, 4 ticks → slots 0, 1, 2 become visible on ticks 1, 2, 3, one per frame. Slot 0 y=3 after tick 4 with flying_rate=0.
- **Escape.** flying_rate=3, Y_LIMIT=112, one plane → y steps 0, 4, …, 112. The next tick pulses `escaped`, vis=0 and escape_count=1. The slot respawns after 4 further ticks.
- **Hit and hit-vs-escape priority.** Pulse hit[0] mid-frame → at the next scan `destroyed` pulses and destroy_count=1. A hit on the escape frame → `destroyed` only, escape_count unchanged.
- **Amount reduction.** plane_amount drops from 10 to 2 with all slots flying → at the next scan slots 2..9 get vis=0 with no escape/destroy pulse. Saturation: plane_amount=20 → behaves exactly as 10.
- **Overrun and timing.** Tick at t and again at t+3 → `overrun`=1, `frame_done` only at t+11 (N=10), no second scan.
- **Mid-scan reset and counter saturation.** Reset at t+5 → all outputs 0 next cycle and no `frame_done`. Force 260 escapes → escape_count stays 255.
